lcd_bus_arbiter: RTL
====================

LCD_BUS_ARBITER -- requirements
Module: lcd_bus_arbiter

Interface
REQ-001 Parameters SHALL be: T_AS_CYC 4, RS/DATA setup before EN rise; T_EN_CYC 12, EN high width; T_H_CYC 4, hold after EN fall; T_SHORT_CYC 2000, 40 us execution wait; T_LONG_CYC 82000, 1.64 ms clear/home wait; T_PWR_CYC 750000, 15 ms power-up wait.
REQ-002 CLOCK_50  in  1  single clock, all logic on rising edge.
REQ-003 RESET_N  in  1  asynchronous, active-low reset.
REQ-004 req  in  2  per-requester write request, held high until ack.
REQ-005 req_rs  in  2  per-requester RS, 0 = command, 1 = character; stable while req is high.
REQ-006 req_data  in  16  per-requester byte, [8i+7:8i] for requester i; stable while req is high.
REQ-007 ack  out  2  one-cycle pulse: request i captured.
REQ-008 done  out  2  one-cycle pulse: requester i's write, including its execution wait, has finished.
REQ-009 busy  out  1  high from capture until done, and during the init sequence.
REQ-010 init_done  out  1  high once the LCD accepts requests.
REQ-011 LCD_DATA  out  8, LCD_RS  out  1, LCD_EN  out  1, LCD_RW  out  1, LCD_ON  out  1, LCD_BLON  out  1: HD44780 bus pins.

Function
REQ-012 LCD_RW SHALL be constant 0; LCD_ON and LCD_BLON SHALL be constant 1.
REQ-013 FSM states SHALL be INIT_WAIT, INIT_ISSUE, IDLE, SETUP, PULSE, HOLD, EXEC.
REQ-014 In IDLE with init_done=1 and any req high, the arbiter SHALL grant one requester and capture its rs/data on that edge.
- The FSM enters SETUP.
- ack[i] is high for exactly the following cycle.
REQ-015 Arbitration SHALL be round-robin: after a grant to i, the other requester has priority; the priority pointer resets to requester 0.
REQ-016 A lone request SHALL be granted regardless of the priority pointer.
REQ-017 SETUP SHALL drive captured RS/DATA with EN=0 for T_AS_CYC cycles.
REQ-018 PULSE SHALL hold EN=1 for T_EN_CYC cycles.
REQ-019 HOLD SHALL hold EN=0 with RS/DATA unchanged for T_H_CYC cycles.
REQ-020 EXEC SHALL wait T_LONG_CYC when rs=0 and data[7:1]==7'b0000000 (codes 0x01, 0x00) or data[7:1]==7'b0000001 (0x02, 0x03); otherwise T_SHORT_CYC.
REQ-021 On the last EXEC cycle, done[i] SHALL pulse and the FSM SHALL return to IDLE.
- A pending request is granted no earlier than the next cycle.
REQ-022 A req dropped before ack SHALL be ignored; a req arriving while busy SHALL wait with no ack.
REQ-023 The delay counter SHALL be 20 bits wide, load (duration-1) and count down to 0, with no wrap-around.
REQ-024 LCD_DATA/LCD_RS SHALL keep their last value in IDLE; LCD_EN SHALL be high only in PULSE.

Reset
REQ-025 While RESET_N=0, outputs SHALL be: LCD_DATA=0, LCD_RS=0, LCD_EN=0, ack=0, done=0, busy=0, init_done=0.
- The priority pointer is set to requester 0.
REQ-026 Reset asserted mid-write SHALL force LCD_EN low immediately (asynchronously) and abandon the write, with no done pulse.
REQ-027 After reset release the FSM SHALL enter INIT_WAIT with LCD_INIT_SEQ_EN defined, otherwise IDLE.

Configuration
REQ-028 Macro LCD_INIT_SEQ_EN defined: after a T_PWR_CYC wait, INIT_ISSUE SHALL write 0x38, 0x0C, 0x01, 0x06 (rs=0) using the SETUP/PULSE/HOLD/EXEC timing.
- busy=1 throughout the sequence.
- init_done rises when the sequence ends.
- No ack is issued before init_done.
REQ-029 Macro LCD_INIT_SEQ_EN undefined: init_done SHALL be 1 from the first cycle after reset release, and no init states or constants are compiled.

Structure
REQ-030 Package lcd_pkg SHALL hold the FSM state enum, the default timing constants and the command codes LCD_CMD_FUNCSET=0x38, LCD_CMD_DISPON=0x0C, LCD_CMD_CLEAR=0x01, LCD_CMD_ENTRY=0x06.
REQ-031 Round-robin selection SHALL live in sub-module lcd_rr_arb (req, pointer -> one-hot grant); timing and FSM stay in the top.

Verification (T_AS=2, T_EN=3, T_H=2, T_SHORT=5, T_LONG=20, T_PWR=10)
REQ-032 req[0]=1, rs=1, data=0x41 -> ack[0] one cycle; EN high 3 cycles, DATA=0x41, RS=1; done[0] pulses 12 cycles after capture.
REQ-033 req[1], rs=0, data=0x01 -> execution wait 20 cycles; done[1] pulses 27 cycles after capture.
REQ-034 req=2'b11 held continuously -> grants in order 0, 1, 0, 1; never two acks in the same cycle.
REQ-035 RESET_N=0 during PULSE -> EN=0 the same cycle, no done; after release with a new req, a correct full write occurs.
REQ-036 With LCD_INIT_SEQ_EN defined: after reset, EN pulses carry 0x38, 0x0C, 0x01, 0x06 in order; init_done rises only after that; a req held from reset gets no ack before init_done.
REQ-037 req[0] pulsed for one cycle during busy and then dropped -> no ack[0], no LCD_EN activity for it.

Source files
------------

// File: rtl/lcd_pkg.sv
`default_nettype none
// lcd_pkg: FSM state type, default HD44780 timing, command codes. Rev 1.0.
// Optional power-up init sequence selected by LCD_INIT_SEQ_EN.
package lcd_pkg;

  localparam int LCD_T_AS_CYC    = 4;
  localparam int LCD_T_EN_CYC    = 12;
  localparam int LCD_T_H_CYC     = 4;
  localparam int LCD_T_SHORT_CYC = 2000;
  localparam int LCD_T_LONG_CYC  = 82000;

`ifdef LCD_INIT_SEQ_EN
  localparam int LCD_T_PWR_CYC = 750000;

  localparam logic [7:0] LCD_CMD_FUNCSET = 8'h38;
  localparam logic [7:0] LCD_CMD_DISPON  = 8'h0C;
  localparam logic [7:0] LCD_CMD_CLEAR   = 8'h01;
  localparam logic [7:0] LCD_CMD_ENTRY   = 8'h06;

  function automatic logic [7:0] init_cmd(input logic [1:0] idx);
    case (idx)
      2'd0:    return LCD_CMD_FUNCSET;
      2'd1:    return LCD_CMD_DISPON;
      2'd2:    return LCD_CMD_CLEAR;
      default: return LCD_CMD_ENTRY;
    endcase
  endfunction
`endif

  typedef enum logic [2:0] {
`ifdef LCD_INIT_SEQ_EN
    INIT_WAIT  = 3'd0,
    INIT_ISSUE = 3'd1,
`endif
    IDLE       = 3'd2,
    SETUP      = 3'd3,
    PULSE      = 3'd4,
    HOLD       = 3'd5,
    EXEC       = 3'd6
  } lcd_state_e;

  // Clear (0x01/0x00) and return-home (0x02/0x03) need the long execution wait.
  function automatic logic is_long_cmd(input logic rs, input logic [7:0] data);
    return !rs && (data[7:2] == 6'd0);
  endfunction

endpackage
`default_nettype wire

// File: rtl/lcd_bus_arbiter_if.sv
`default_nettype none
// lcd_bus_arbiter_if: two-requester write handshake and status bundle. Rev 1.0.
interface lcd_bus_arbiter_if;
  logic [1:0]  req;
  logic [1:0]  req_rs;
  logic [15:0] req_data;
  logic [1:0]  ack;
  logic [1:0]  done;
  logic        busy;
  logic        init_done;

  modport master (output req, req_rs, req_data, input ack, done, busy, init_done);
  modport slave  (input req, req_rs, req_data, output ack, done, busy, init_done);
endinterface
`default_nettype wire

// File: rtl/lcd_rr_arb.sv
`default_nettype none
// lcd_rr_arb: two-way round-robin selector, one-hot grant. Rev 1.0.
module lcd_rr_arb (
  input  logic [1:0] req,
  input  logic       ptr,
  output logic [1:0] grant
);
  // A lone request wins outright; the pointer only breaks ties.
  always_comb begin
    grant = req;
    if (req == 2'b11) grant = ptr ? 2'b10 : 2'b01;
  end
endmodule
`default_nettype wire

// File: rtl/lcd_bus_arbiter.sv
`default_nettype none
// lcd_bus_arbiter: shares an HD44780 write bus between two requesters. Rev 1.0.
// Optional power-up init sequence selected by LCD_INIT_SEQ_EN.
module lcd_bus_arbiter
  import lcd_pkg::*;
#(
  parameter int T_AS_CYC    = LCD_T_AS_CYC,
  parameter int T_EN_CYC    = LCD_T_EN_CYC,
  parameter int T_H_CYC     = LCD_T_H_CYC,
  parameter int T_SHORT_CYC = LCD_T_SHORT_CYC,
  parameter int T_LONG_CYC  = LCD_T_LONG_CYC
`ifdef LCD_INIT_SEQ_EN
  , parameter int T_PWR_CYC = LCD_T_PWR_CYC
`endif
) (
  input  logic             CLOCK_50,
  input  logic             RESET_N,
  lcd_bus_arbiter_if.slave bus,
  output logic [7:0]       LCD_DATA,
  output logic             LCD_RS,
  output logic             LCD_EN,
  output logic             LCD_RW,
  output logic             LCD_ON,
  output logic             LCD_BLON
);

  localparam logic [19:0] LOAD_AS    = 20'(T_AS_CYC - 1);
  localparam logic [19:0] LOAD_EN    = 20'(T_EN_CYC - 1);
  localparam logic [19:0] LOAD_H     = 20'(T_H_CYC - 1);
  localparam logic [19:0] LOAD_SHORT = 20'(T_SHORT_CYC - 1);
  localparam logic [19:0] LOAD_LONG  = 20'(T_LONG_CYC - 1);
`ifdef LCD_INIT_SEQ_EN
  localparam logic [19:0] LOAD_PWR   = 20'(T_PWR_CYC - 1);
`endif

  lcd_state_e  state;
  logic [19:0] cnt;
  logic [19:0] exec_len;
  logic [1:0]  ack, done, grant;
  logic        busy, init_done;
  logic        ptr, owner, exec_long, is_user;
  logic        sel_owner, sel_rs;
  logic [7:0]  sel_data;
`ifdef LCD_INIT_SEQ_EN
  logic [1:0]  init_idx;
  logic        in_init;
  assign is_user = !in_init;
`else
  assign is_user = 1'b1;
`endif

  assign LCD_RW   = 1'b0;
  assign LCD_ON   = 1'b1;
  assign LCD_BLON = 1'b1;

  assign bus.ack       = ack;
  assign bus.done      = done;
  assign bus.busy      = busy;
  assign bus.init_done = init_done;

  lcd_rr_arb u_rr_arb (.req(bus.req), .ptr(ptr), .grant(grant));

  assign sel_owner = grant[1];
  assign sel_data  = sel_owner ? bus.req_data[15:8] : bus.req_data[7:0];
  assign sel_rs    = bus.req_rs[sel_owner];
  assign exec_len  = exec_long ? LOAD_LONG : LOAD_SHORT;

  always_ff @(posedge CLOCK_50 or negedge RESET_N) begin
    if (!RESET_N) begin
`ifdef LCD_INIT_SEQ_EN
      state    <= INIT_WAIT;
      cnt      <= LOAD_PWR;
      init_idx <= 2'd0;
      in_init  <= 1'b1;
`else
      state    <= IDLE;
      cnt      <= '0;
`endif
      LCD_DATA  <= '0;
      LCD_RS    <= 1'b0;
      LCD_EN    <= 1'b0;
      ack       <= '0;
      done      <= '0;
      busy      <= 1'b0;
      init_done <= 1'b0;
      ptr       <= 1'b0;
      owner     <= 1'b0;
      exec_long <= 1'b0;
    end else begin
      ack  <= '0;
      done <= '0;
`ifndef LCD_INIT_SEQ_EN
      init_done <= 1'b1;
`endif
      case (state)
`ifdef LCD_INIT_SEQ_EN
        INIT_WAIT: begin
          busy <= 1'b1;
          if (cnt == '0) state <= INIT_ISSUE;
          else           cnt   <= cnt - 20'd1;
        end
        INIT_ISSUE: begin
          LCD_DATA  <= init_cmd(init_idx);
          LCD_RS    <= 1'b0;
          exec_long <= is_long_cmd(1'b0, init_cmd(init_idx));
          cnt       <= LOAD_AS;
          state     <= SETUP;
        end
`endif
        IDLE: begin
          if (init_done && grant != 2'b00) begin
            owner     <= sel_owner;
            LCD_DATA  <= sel_data;
            LCD_RS    <= sel_rs;
            exec_long <= is_long_cmd(sel_rs, sel_data);
            ack       <= grant;
            busy      <= 1'b1;
            ptr       <= grant[0];
            cnt       <= LOAD_AS;
            state     <= SETUP;
          end
        end
        SETUP: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b1;
            cnt    <= LOAD_EN;
            state  <= PULSE;
          end else cnt <= cnt - 20'd1;
        end
        PULSE: begin
          if (cnt == '0) begin
            LCD_EN <= 1'b0;
            cnt    <= LOAD_H;
            state  <= HOLD;
          end else cnt <= cnt - 20'd1;
        end
        HOLD: begin
          if (cnt == '0) begin
            cnt   <= exec_len;
            state <= EXEC;
            if (exec_len == '0 && is_user) done[owner] <= 1'b1;
          end else cnt <= cnt - 20'd1;
        end
        EXEC: begin
          // done is registered, so it is launched one count early to land on the last cycle.
          if (cnt == '0) begin
`ifdef LCD_INIT_SEQ_EN
            if (in_init) begin
              if (init_idx == 2'd3) begin
                in_init   <= 1'b0;
                init_done <= 1'b1;
                busy      <= 1'b0;
                state     <= IDLE;
              end else begin
                init_idx <= init_idx + 2'd1;
                state    <= INIT_ISSUE;
              end
            end else
`endif
            begin
              busy  <= 1'b0;
              state <= IDLE;
            end
          end else begin
            cnt <= cnt - 20'd1;
            if (cnt == 20'd1 && is_user) done[owner] <= 1'b1;
          end
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire
